// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocator: FSM encoding, packed-word index
// helpers and the default note-tag width.
package synth_pkg;

  localparam int NOTE_BITS_DEFAULT = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic int word_lsb(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int word_msb(input int idx, input int width);
    return (idx + 1) * width - 1;
  endfunction

endpackage

// File: rtl/voice_slot.sv
// One synthesis channel: active flag, note tag, carrier and modulator words,
// with clear (higher priority) and write ports plus a tag-compare output.
module voice_slot
  import synth_pkg::*;
#(
  parameter int NUM_BITS  = 32,
  parameter int NOTE_BITS = NOTE_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 clr,
  input  logic [NOTE_BITS-1:0] wr_tag,
  input  logic [NUM_BITS-1:0]  wr_car,
  input  logic [NUM_BITS-1:0]  wr_mod,
  input  logic [NOTE_BITS-1:0] cmp_tag,
  output logic                 active,
  output logic                 tag_match,
  output logic [NUM_BITS-1:0]  car_word,
  output logic [NUM_BITS-1:0]  mod_word
);

  logic                 active_q, active_d;
  logic [NOTE_BITS-1:0] tag_q, tag_d;
  logic [NUM_BITS-1:0]  car_q, car_d;
  logic [NUM_BITS-1:0]  mod_q, mod_d;

  always_comb begin
    active_d = active_q;
    tag_d    = tag_q;
    car_d    = car_q;
    mod_d    = mod_q;
    if (clr) begin
      active_d = 1'b0;
      tag_d    = '0;
      car_d    = '0;
      mod_d    = '0;
    end else if (wr_en) begin
      active_d = 1'b1;
      tag_d    = wr_tag;
      car_d    = wr_car;
      mod_d    = wr_mod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q <= 1'b0;
      tag_q    <= '0;
      car_q    <= '0;
      mod_q    <= '0;
    end else begin
      active_q <= active_d;
      tag_q    <= tag_d;
      car_q    <= car_d;
      mod_q    <= mod_d;
    end
  end

  assign active    = active_q;
  assign tag_match = active_q && (tag_q == cmp_tag);
  assign car_word  = car_q;
  assign mod_word  = mod_q;

endmodule

// File: rtl/voice_allocator.sv
// Note-on/off allocator: sequential channel scan then a single commit write.
// Define VOICE_STEAL_EN to steal a channel (round-robin) instead of dropping when full.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_BITS     = 32,
  parameter int NUM_CHANNELS = 16,
  parameter int NOTE_BITS    = NOTE_BITS_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_on,
  input  logic [NOTE_BITS-1:0]             cmd_note,
  input  logic [NUM_BITS-2:0]              cmd_car,
  input  logic [NUM_BITS-1:0]              cmd_mod,
  input  logic                             panic,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_out,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_out,
  output logic [NUM_CHANNELS-1:0]          available,
  output logic                             cmd_drop,
  output logic                             cmd_steal
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 on_q, on_d;
  logic [NOTE_BITS-1:0] note_q, note_d;
  logic [NUM_BITS-2:0]  car_q, car_d;
  logic [NUM_BITS-1:0]  mod_q, mod_d;
  logic                 match_found_q, match_found_d;
  logic [IDX_W-1:0]     match_idx_q, match_idx_d;
  logic                 free_found_q, free_found_d;
  logic [IDX_W-1:0]     free_idx_q, free_idx_d;
  logic                 drop_q, drop_d;

  logic [NUM_CHANNELS-1:0] active_vec, match_vec, wr_en_vec, clr_vec;
  logic [NUM_BITS-1:0]     car_word [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     mod_word [NUM_CHANNELS];

`ifdef VOICE_STEAL_EN
  logic             steal_q, steal_d;
  logic [IDX_W-1:0] steal_ptr_q, steal_ptr_d;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    on_d          = on_q;
    note_d        = note_q;
    car_d         = car_q;
    mod_d         = mod_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    drop_d        = 1'b0;
    wr_en_vec     = '0;
    clr_vec       = '0;
`ifdef VOICE_STEAL_EN
    steal_d       = 1'b0;
    steal_ptr_d   = steal_ptr_q;
`endif
    // panic overrides everything, including a command arriving on this edge
    if (panic) begin
      state_d       = ST_IDLE;
      clr_vec       = '1;
      match_found_d = 1'b0;
      free_found_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            on_d          = cmd_on;
            note_d        = cmd_note;
            car_d         = cmd_car;
            mod_d         = cmd_mod;
            idx_d         = '0;
            match_found_d = 1'b0;
            free_found_d  = 1'b0;
            state_d       = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (match_vec[idx_q] && !match_found_q) begin
            match_found_d = 1'b1;
            match_idx_d   = idx_q;
          end
          if (!active_vec[idx_q] && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
          if (idx_q == LAST_IDX) state_d = ST_COMMIT;
          else idx_d = idx_q + IDX_W'(1);
        end
        ST_COMMIT: begin
          state_d = ST_IDLE;
          if (on_q) begin
            if (match_found_q) wr_en_vec[match_idx_q] = 1'b1;
            else if (free_found_q) wr_en_vec[free_idx_q] = 1'b1;
            else begin
`ifdef VOICE_STEAL_EN
              wr_en_vec[steal_ptr_q] = 1'b1;
              steal_d     = 1'b1;
              steal_ptr_d = (steal_ptr_q == LAST_IDX) ? '0 : steal_ptr_q + IDX_W'(1);
`else
              drop_d = 1'b1;
`endif
            end
          end else if (match_found_q) begin
            clr_vec[match_idx_q] = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      on_q          <= 1'b0;
      note_q        <= '0;
      car_q         <= '0;
      mod_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      on_q          <= on_d;
      note_q        <= note_d;
      car_q         <= car_d;
      mod_q         <= mod_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      drop_q        <= drop_d;
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      steal_q     <= 1'b0;
      steal_ptr_q <= '0;
    end else begin
      steal_q     <= steal_d;
      steal_ptr_q <= steal_ptr_d;
    end
  end
  assign cmd_steal = steal_q;
`else
  assign cmd_steal = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_slot
    voice_slot #(
      .NUM_BITS  (NUM_BITS),
      .NOTE_BITS (NOTE_BITS)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en_vec[i]),
      .clr       (clr_vec[i]),
      .wr_tag    (note_q),
      .wr_car    ({1'b1, car_q}),
      .wr_mod    (mod_q),
      .cmp_tag   (note_q),
      .active    (active_vec[i]),
      .tag_match (match_vec[i]),
      .car_word  (car_word[i]),
      .mod_word  (mod_word[i])
    );
    assign carrier_out[word_msb(i, NUM_BITS):word_lsb(i, NUM_BITS)]   = car_word[i];
    assign modulator_out[word_msb(i, NUM_BITS):word_lsb(i, NUM_BITS)] = mod_word[i];
  end

  assign available = ~active_vec;
  assign cmd_ready = (state_q == ST_IDLE);
  assign cmd_drop  = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: behavioural channel-table model,
// per-cycle comparison, directed literal checks and randomized commands.
module tb_voice_allocator;

  localparam int N  = 16;
  localparam int NB = 32;
  localparam int NT = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_on;
  logic [NT-1:0]   cmd_note;
  logic [NB-2:0]   cmd_car;
  logic [NB-1:0]   cmd_mod;
  logic            panic;
  logic [NB*N-1:0] carrier_out;
  logic [NB*N-1:0] modulator_out;
  logic [N-1:0]    available;
  logic            cmd_drop;
  logic            cmd_steal;

  voice_allocator #(.NUM_BITS(NB), .NUM_CHANNELS(N), .NOTE_BITS(NT)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_on        (cmd_on),
    .cmd_note      (cmd_note),
    .cmd_car       (cmd_car),
    .cmd_mod       (cmd_mod),
    .panic         (panic),
    .carrier_out   (carrier_out),
    .modulator_out (modulator_out),
    .available     (available),
    .cmd_drop      (cmd_drop),
    .cmd_steal     (cmd_steal)
  );

  always #5 clk = ~clk;

  // channel table as the allocator should hold it
  bit          m_active [N];
  logic [6:0]  m_tag    [N];
  logic [31:0] m_car    [N];
  logic [31:0] m_mod    [N];
  int          m_ptr;
  bit          exp_ready;
  bit          exp_drop;
  bit          exp_steal;
  bit          check_en = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] chan(input logic [NB*N-1:0] bus, input int i);
    return bus[i*NB +: NB];
  endfunction

  task automatic modelClear();
    for (int i = 0; i < N; i++) begin
      m_active[i] = 1'b0;
      m_tag[i]    = '0;
      m_car[i]    = '0;
      m_mod[i]    = '0;
    end
  endtask

  task automatic modelReset();
    modelClear();
    m_ptr     = 0;
    exp_ready = 1'b1;
    exp_drop  = 1'b0;
    exp_steal = 1'b0;
  endtask

  task automatic modelCommit(input bit on, input logic [6:0] note,
                             input logic [30:0] car, input logic [31:0] mod);
    int m = -1;
    int f = -1;
    int t = -1;
    for (int i = 0; i < N; i++) begin
      if (m < 0 && m_active[i] && m_tag[i] == note) m = i;
      if (f < 0 && !m_active[i]) f = i;
    end
    if (on) begin
      if (m >= 0) t = m;
      else if (f >= 0) t = f;
      else begin
`ifdef VOICE_STEAL_EN
        t = m_ptr;
        m_ptr = (m_ptr + 1) % N;
        exp_steal = 1'b1;
`else
        exp_drop = 1'b1;
`endif
      end
      if (t >= 0) begin
        m_active[t] = 1'b1;
        m_tag[t]    = note;
        m_car[t]    = {1'b1, car};
        m_mod[t]    = mod;
      end
    end else if (m >= 0) begin
      m_active[m] = 1'b0;
      m_tag[m]    = '0;
      m_car[m]    = '0;
      m_mod[m]    = '0;
    end
  endtask

  always @(negedge clk) begin : compare_proc
    logic [NB*N-1:0] ec;
    logic [NB*N-1:0] em;
    logic [N-1:0]    ea;
    if (check_en) begin
      for (int i = 0; i < N; i++) begin
        ec[i*NB +: NB] = m_car[i];
        em[i*NB +: NB] = m_mod[i];
        ea[i]          = ~m_active[i];
      end
      checkOutput("carrier_out", 512'(carrier_out), 512'(ec));
      checkOutput("modulator_out", 512'(modulator_out), 512'(em));
      checkOutput("available", 512'(available), 512'(ea));
      checkOutput("cmd_ready", 512'(cmd_ready), 512'(exp_ready));
      checkOutput("cmd_drop", 512'(cmd_drop), 512'(exp_drop));
      checkOutput("cmd_steal", 512'(cmd_steal), 512'(exp_steal));
    end
  end

  task automatic scrambleInputs();
    cmd_on   = 1'($urandom);
    cmd_note = 7'($urandom);
    cmd_car  = 31'($urandom);
    cmd_mod  = $urandom;
  endtask

  // one full command; returns one cycle after the commit edge
  task automatic applyStimulus(input bit on, input logic [6:0] note, input logic [30:0] car,
                               input logic [31:0] mod, input bit panic_at_accept = 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_on    = on;
    cmd_note  = note;
    cmd_car   = car;
    cmd_mod   = mod;
    panic     = panic_at_accept;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    panic     = 1'b0;
    exp_drop  = 1'b0;
    exp_steal = 1'b0;
    scrambleInputs();
    if (panic_at_accept) begin
      modelClear();
    end else begin
      exp_ready = 1'b0;
      repeat (N + 1) @(posedge clk);
      #1;
      modelCommit(on, note, car, mod);
      exp_ready = 1'b1;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      exp_drop  = 1'b0;
      exp_steal = 1'b0;
    end
  endtask

  task automatic interruptScan(input int k, input bit use_reset);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_on    = 1'b1;
    cmd_note  = 7'd5;
    cmd_car   = 31'h123;
    cmd_mod   = 32'h456;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    exp_drop  = 1'b0;
    exp_steal = 1'b0;
    exp_ready = 1'b0;
    repeat (k) @(posedge clk);
    @(negedge clk);
    if (use_reset) rst = 1'b0;
    else panic = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    panic = 1'b0;
    if (use_reset) modelReset();
    else begin
      modelClear();
      exp_ready = 1'b1;
    end
    checkOutput("interrupt_available", 512'(available), 512'(16'hFFFF));
    checkOutput("interrupt_ready", 512'(cmd_ready), 512'(1'b1));
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    panic     = 1'b0;
    cmd_on    = 1'b0;
    cmd_note  = '0;
    cmd_car   = '0;
    cmd_mod   = '0;
    modelReset();
    @(posedge clk);
    #1;
    check_en = 1'b1;
    checkOutput("reset_available", 512'(available), 512'(16'hFFFF));
    checkOutput("reset_carrier", 512'(carrier_out), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    idleCycles(2);

    applyStimulus(1'b1, 7'd60, 31'h1000, 32'h200);
    checkOutput("on60_car0", 512'(chan(carrier_out, 0)), 512'(32'h80001000));
    checkOutput("on60_mod0", 512'(chan(modulator_out, 0)), 512'(32'h200));
    checkOutput("on60_avail", 512'(available), 512'(16'hFFFE));

    applyStimulus(1'b1, 7'd60, 31'h2000, 32'h300);
    checkOutput("retrig_car0", 512'(chan(carrier_out, 0)), 512'(32'h80002000));
    checkOutput("retrig_avail", 512'(available), 512'(16'hFFFE));

    applyStimulus(1'b1, 7'd61, 31'h3000, 32'h0);
    applyStimulus(1'b0, 7'd60, 31'h0, 32'h0);
    checkOutput("off60_car0", 512'(chan(carrier_out, 0)), 512'(32'h0));
    checkOutput("off60_mod0", 512'(chan(modulator_out, 0)), 512'(32'h0));
    checkOutput("off60_avail", 512'(available), 512'(16'hFFFD));
    applyStimulus(1'b0, 7'd99, 31'h0, 32'h0);
    checkOutput("off99_avail", 512'(available), 512'(16'hFFFD));
    checkOutput("off99_car1", 512'(chan(carrier_out, 1)), 512'(32'h80003000));

    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, 7'(70 + i), 31'(16'h100 + i), 32'(i));
    checkOutput("full_avail", 512'(available), 512'(16'h0000));
    applyStimulus(1'b1, 7'd100, 31'h7777, 32'h8888);
`ifdef VOICE_STEAL_EN
    checkOutput("steal_pulse", 512'(cmd_steal), 512'(1'b1));
    checkOutput("steal_car0", 512'(chan(carrier_out, 0)), 512'(32'h80007777));
    applyStimulus(1'b1, 7'd101, 31'h5555, 32'h1);
    checkOutput("steal_car1", 512'(chan(carrier_out, 1)), 512'(32'h80005555));
`else
    checkOutput("drop_pulse", 512'(cmd_drop), 512'(1'b1));
    checkOutput("drop_car0", 512'(chan(carrier_out, 0)), 512'(32'h80000100));
`endif
    idleCycles(1);
    checkOutput("pulse_cleared", 512'({cmd_drop, cmd_steal}), 512'(2'b00));

    interruptScan(7, 1'b0);
    idleCycles(2);

    applyStimulus(1'b1, 7'd42, 31'h42, 32'h42, 1'b1);
    checkOutput("panic_accept_avail", 512'(available), 512'(16'hFFFF));
    idleCycles(1);

    for (int n = 0; n < 90; n++) begin
      bit pa;
      pa = ($urandom_range(0, 19) == 0);
      applyStimulus($urandom_range(0, 9) < 6, 7'($urandom_range(0, 23)),
                    31'($urandom), ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom, pa);
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
    end

    interruptScan(3, 1'b1);
    idleCycles(1);
    applyStimulus(1'b1, 7'd9, 31'h99, 32'h0);
    checkOutput("after_reset_car0", 512'(chan(carrier_out, 0)), 512'(32'h80000099));
    idleCycles(2);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
